sc_scbc_prx: RTL and testbench

ULPI packet receiver for the USB host controller. It sits beside the ULPI interface controller on the ULPI clock and watches DIR/NXT/DATA_I while the PHY owns the bus. It decodes RX CMD bytes and receive data bytes into USB packets (handshake and DATA0/1), checks the PID and CRC16, and streams the payload to the transaction controller. It is the receive counterpart of the token/data transmit path.

---
 rtl/sc_scbc_pkg.sv | 52 +++++
 rtl/sc_scbc_prx_if.sv | 37 +++
 rtl/sc_scbc_crc16.sv | 18 +
 rtl/sc_scbc_prx.sv | 175 +++++++++++++++++
 tb/tb_sc_scbc_prx.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/sc_scbc_pkg.sv
// Shared USB definitions for the host-controller packet paths: PIDs, CRC16
// constants, ULPI RxEvent encodings and the receiver FSM states.
package sc_scbc_pkg;

  typedef enum logic [3:0] {
    PID_EXT   = 4'h0,
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_PING  = 4'h4,
    PID_SOF   = 4'h5,
    PID_NYET  = 4'h6,
    PID_DATA2 = 4'h7,
    PID_SPLIT = 4'h8,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_PRE   = 4'hC,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE,
    PID_MDATA = 4'hF
  } usb_pid_t;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R   = 16'hA001;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  typedef enum logic [1:0] {
    RXEV_INACTIVE = 2'b00,
    RXEV_ACTIVE   = 2'b01,
    RXEV_HOSTDISC = 2'b10,
    RXEV_ERROR    = 2'b11
  } rx_event_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_HSK,
    S_DATA,
    S_DRAIN,
    S_DONE
  } prx_state_t;

  function automatic logic pid_is_hsk(input logic [3:0] p);
    return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL) || (p == PID_NYET);
  endfunction

  function automatic logic pid_is_data(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

endpackage

// File: rtl/sc_scbc_prx_if.sv
// ULPI receive side plus packet stream toward the transaction controller.
// SC_SCBC_PRX_RXCMD_EN adds the RX CMD line-state / VBUS / host-disconnect outputs.
interface sc_scbc_prx_if;
  logic        DIR;
  logic        NXT;
  logic [7:0]  DATA_I;
  logic        PKT_RX_START;
  logic [3:0]  PKT_RX_PID;
  logic [7:0]  PKT_RX_DAT;
  logic        PKT_RX_DVALID;
  logic        PKT_RX_END;
  logic [3:0]  PKT_RX_ERR;
  logic [10:0] PKT_RX_LEN;
`ifdef SC_SCBC_PRX_RXCMD_EN
  logic [1:0]  RX_LINESTATE;
  logic [1:0]  RX_VBUS;
  logic [0:0]  RX_HOSTDISC;
`endif

  modport slave (
    input  DIR, NXT, DATA_I,
    output PKT_RX_START, PKT_RX_PID, PKT_RX_DAT, PKT_RX_DVALID,
           PKT_RX_END, PKT_RX_ERR, PKT_RX_LEN
`ifdef SC_SCBC_PRX_RXCMD_EN
    , output RX_LINESTATE, RX_VBUS, RX_HOSTDISC
`endif
  );

  modport master (
    output DIR, NXT, DATA_I,
    input  PKT_RX_START, PKT_RX_PID, PKT_RX_DAT, PKT_RX_DVALID,
           PKT_RX_END, PKT_RX_ERR, PKT_RX_LEN
`ifdef SC_SCBC_PRX_RXCMD_EN
    , input RX_LINESTATE, RX_VBUS, RX_HOSTDISC
`endif
  );
endinterface

// File: rtl/sc_scbc_crc16.sv
// Combinational byte-wide USB CRC16 step (reflected, LSB first); shared by RX and TX.
module sc_scbc_crc16
  import sc_scbc_pkg::*;
(
  input  logic [15:0] i_crc_in,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc_out
);
  logic [15:0] w_acc;

  always_comb begin
    w_acc = i_crc_in ^ {8'h00, i_byte};
    for (int unsigned i = 0; i < 8; i++) begin
      w_acc = w_acc[0] ? ((w_acc >> 1) ^ CRC16_POLY_R) : (w_acc >> 1);
    end
    o_crc_out = w_acc;
  end
endmodule

// File: rtl/sc_scbc_prx.sv
// ULPI packet receiver: decodes RX CMD / data bytes into handshake and DATA0/1
// packets with PID and CRC16 checks. SC_SCBC_PRX_RXCMD_EN exports RX CMD status.
module sc_scbc_prx
  import sc_scbc_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 1023
) (
  input  logic          ULPICLK,
  input  logic          ULPIRST,
  sc_scbc_prx_if.slave  ulpi
);
  localparam logic [10:0] LP_MAX = 11'(MAX_PAYLOAD);
  localparam logic [10:0] LP_LIM = 11'(MAX_PAYLOAD + 2);

  prx_state_t  r_state, w_state_nxt;
  logic        r_dir_q, r_rx_active;
  logic [15:0] r_crc;
  logic [10:0] r_cnt;
  logic [7:0]  r_h0, r_h1;
  logic        r_flg_ovf, r_flg_rxe, r_flg_crc, r_flg_pid;
  logic        r_start, r_dvalid;
  logic [3:0]  r_pid;
  logic [7:0]  r_dat;

  logic        w_turn, w_rise_ta, w_fall_ta, w_data, w_rxcmd;
  logic        w_act_nxt, w_pkt_start, w_pkt_end, w_rxerr_evt;
  logic        w_pid_ok, w_in_pkt;
  rx_event_t   w_rxev;
  logic [15:0] w_crc_nxt;
  logic [10:0] w_cnt_inc, w_len;

  sc_scbc_crc16 u_crc (
    .i_crc_in  (r_crc),
    .i_byte    (ulpi.DATA_I),
    .o_crc_out (w_crc_nxt)
  );

  always_comb begin
    w_rise_ta = ulpi.DIR && !r_dir_q;
    w_fall_ta = !ulpi.DIR && r_dir_q;
    w_turn    = w_rise_ta || w_fall_ta;
    w_data    = ulpi.DIR && !w_turn && ulpi.NXT && r_rx_active;
    w_rxcmd   = ulpi.DIR && !w_turn && !ulpi.NXT;
    w_rxev    = rx_event_t'(ulpi.DATA_I[5:4]);
    w_act_nxt = r_rx_active;
    if (w_rise_ta && ulpi.NXT) w_act_nxt = 1'b1;
    if (w_fall_ta)             w_act_nxt = 1'b0;
    if (w_rxcmd)               w_act_nxt = ulpi.DATA_I[4];
    w_pkt_start = !r_rx_active && w_act_nxt;
    w_pkt_end   = r_rx_active && !w_act_nxt;
    w_rxerr_evt = r_rx_active && ((w_rxcmd && w_rxev == RXEV_ERROR) || w_fall_ta);
    w_pid_ok    = (ulpi.DATA_I[7:4] == ~ulpi.DATA_I[3:0]) &&
                  (pid_is_hsk(ulpi.DATA_I[3:0]) || pid_is_data(ulpi.DATA_I[3:0]));
    w_in_pkt    = (r_state == S_PID) || (r_state == S_HSK) ||
                  (r_state == S_DATA) || (r_state == S_DRAIN);
    w_cnt_inc   = r_cnt + 11'd1;
    if (r_cnt < 11'd2)       w_len = '0;
    else if (r_cnt > LP_LIM) w_len = LP_MAX;
    else                     w_len = r_cnt - 11'd2;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_pkt_start) w_state_nxt = S_PID;
      S_PID: begin
        if (w_data) begin
          if (!w_pid_ok)                        w_state_nxt = S_DRAIN;
          else if (pid_is_hsk(ulpi.DATA_I[3:0])) w_state_nxt = S_HSK;
          else                                   w_state_nxt = S_DATA;
        end else if (w_pkt_end) begin
          w_state_nxt = S_IDLE;  // no byte after rx_active: dropped silently
        end
      end
      S_HSK, S_DATA, S_DRAIN: if (w_pkt_end) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_pkt_start ? S_PID : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ULPICLK) begin
    if (ULPIRST) begin
      r_state     <= S_IDLE;
      r_dir_q     <= 1'b1;  // forces a fresh DIR rise before the next packet
      r_rx_active <= 1'b0;
      r_crc       <= CRC16_INIT;
      r_cnt       <= '0;
      r_h0        <= '0;
      r_h1        <= '0;
      r_flg_ovf   <= 1'b0;
      r_flg_rxe   <= 1'b0;
      r_flg_crc   <= 1'b0;
      r_flg_pid   <= 1'b0;
      r_start     <= 1'b0;
      r_dvalid    <= 1'b0;
      r_pid       <= '0;
      r_dat       <= '0;
    end else begin
      r_dir_q     <= ulpi.DIR;
      r_rx_active <= w_act_nxt;
      r_state     <= w_state_nxt;
      r_start     <= 1'b0;
      r_dvalid    <= 1'b0;

      if (w_state_nxt == S_PID && r_state != S_PID) begin
        r_crc     <= CRC16_INIT;
        r_cnt     <= '0;
        r_h0      <= '0;
        r_h1      <= '0;
        r_flg_ovf <= 1'b0;
        r_flg_rxe <= 1'b0;
        r_flg_crc <= 1'b0;
        r_flg_pid <= 1'b0;
      end

      if (w_rxerr_evt && w_in_pkt) r_flg_rxe <= 1'b1;

      if (r_state == S_PID && w_data) begin
        r_flg_pid <= !w_pid_ok;
        if (w_pid_ok) begin
          r_pid   <= ulpi.DATA_I[3:0];
          r_start <= 1'b1;
        end
      end

      if (r_state == S_HSK && w_data) r_flg_pid <= 1'b1;

      // The pipe delays by two bytes so the trailing CRC pair is never emitted.
      if (r_state == S_DATA && w_data) begin
        r_crc <= w_crc_nxt;
        r_h0  <= ulpi.DATA_I;
        r_h1  <= r_h0;
        if (r_cnt <= LP_LIM) r_cnt <= w_cnt_inc;
        if (w_cnt_inc > LP_LIM) r_flg_ovf <= 1'b1;
        if (w_cnt_inc >= 11'd3 && w_cnt_inc <= LP_LIM) begin
          r_dat    <= r_h1;
          r_dvalid <= 1'b1;
        end
      end

      if (r_state == S_DATA && w_pkt_end)
        r_flg_crc <= (r_crc != CRC16_RESIDUAL) || (r_cnt < 11'd2);
    end
  end

  assign ulpi.PKT_RX_START  = r_start;
  assign ulpi.PKT_RX_PID    = r_pid;
  assign ulpi.PKT_RX_DAT    = r_dat;
  assign ulpi.PKT_RX_DVALID = r_dvalid;
  assign ulpi.PKT_RX_END    = (r_state == S_DONE);
  assign ulpi.PKT_RX_ERR    = (r_state == S_DONE) ?
                              {r_flg_ovf, r_flg_rxe, r_flg_crc, r_flg_pid} : '0;
  assign ulpi.PKT_RX_LEN    = (r_state == S_DONE) ? w_len : '0;

`ifdef SC_SCBC_PRX_RXCMD_EN
  logic [1:0] r_linestate, r_vbus;
  logic       r_hostdisc;

  always_ff @(posedge ULPICLK) begin
    if (ULPIRST) begin
      r_linestate <= '0;
      r_vbus      <= '0;
      r_hostdisc  <= 1'b0;
    end else if (w_rxcmd) begin
      r_linestate <= ulpi.DATA_I[1:0];
      r_vbus      <= ulpi.DATA_I[3:2];
      r_hostdisc  <= (w_rxev == RXEV_HOSTDISC);
    end
  end

  assign ulpi.RX_LINESTATE = r_linestate;
  assign ulpi.RX_VBUS      = r_vbus;
  assign ulpi.RX_HOSTDISC  = r_hostdisc;
`endif
endmodule

// File: tb/tb_sc_scbc_prx.sv
// Scoreboard bench for sc_scbc_prx: expected START/DAT/END events queued at
// stimulus time and compared as the receiver produces them.
module tb_sc_scbc_prx;
  localparam int MAXP = 8;

  logic ULPICLK = 1'b0;
  logic ULPIRST;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [3:0]  exp_start[$];
  logic [7:0]  exp_dat[$];
  logic [14:0] exp_end[$];
  logic [7:0]  pl[$];

  sc_scbc_prx_if ifc ();

  sc_scbc_prx #(.MAX_PAYLOAD(MAXP)) dut (
    .ULPICLK (ULPICLK),
    .ULPIRST (ULPIRST),
    .ulpi    (ifc)
  );

  always #5 ULPICLK = ~ULPICLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {8'h00, q[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic cyc(input logic dir, input logic nxt, input logic [7:0] d);
    ifc.DIR    = dir;
    ifc.NXT    = nxt;
    ifc.DATA_I = d;
    @(posedge ULPICLK);
    #1;
  endtask

  // crc_mode: 0 correct CRC appended, 1 last CRC byte inverted, 2 no CRC bytes
  task automatic send_pkt(input logic [7:0] pidb, input logic [7:0] pay[$],
                          input int crc_mode, input bit mid_err, input bit dir_end);
    logic [7:0]  b[$];
    logic [15:0] c;
    logic [3:0]  p, err;
    bit          hsk, dat, rxe, ovf, crcbad;
    int          n, ne;
    b = pay;
    if (crc_mode != 2) begin
      c = ~crc16(pay);
      b.push_back(c[7:0]);
      b.push_back(crc_mode == 1 ? ~c[15:8] : c[15:8]);
    end
    n   = b.size();
    p   = pidb[3:0];
    hsk = (pidb[7:4] == ~p) && (p inside {4'h2, 4'hA, 4'hE, 4'h6});
    dat = (pidb[7:4] == ~p) && (p inside {4'h3, 4'hB});
    rxe = mid_err || dir_end;
    ne  = 0;
    if (!(hsk || dat)) begin
      err = {1'b0, rxe, 1'b0, 1'b1};
    end else if (hsk) begin
      exp_start.push_back(p);
      err = {1'b0, rxe, 1'b0, n > 0};
    end else begin
      exp_start.push_back(p);
      ne = (n < 2) ? 0 : n - 2;
      if (ne > MAXP) ne = MAXP;
      for (int k = 0; k < ne; k++) exp_dat.push_back(b[k]);
      ovf    = n > MAXP + 2;
      crcbad = (n < 2) || (crc16(b) != 16'hB001);
      err    = {ovf, rxe, crcbad, 1'b0};
    end
    exp_end.push_back({err, 11'(ne)});

    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, pidb);
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, 1'b1, b[k]);
      if (mid_err && k == 0) cyc(1'b1, 1'b0, 8'h30);
    end
    if (dir_end) begin
      cyc(1'b0, 1'b0, 8'h00);
    end else begin
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
    end
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

  always @(negedge ULPICLK) begin
    if (ifc.PKT_RX_START) begin
      if (exp_start.size() == 0) chk("start_extra", exp_start.size(), 1);
      else chk("start_pid", ifc.PKT_RX_PID, exp_start.pop_front());
    end
    if (ifc.PKT_RX_DVALID) begin
      if (exp_dat.size() == 0) chk("dat_extra", exp_dat.size(), 1);
      else chk("dat", ifc.PKT_RX_DAT, exp_dat.pop_front());
    end
    if (ifc.PKT_RX_END) begin
      logic [14:0] e;
      chk("end_dv_excl", ifc.PKT_RX_DVALID, 0);
      if (exp_end.size() == 0) chk("end_extra", exp_end.size(), 1);
      else begin
        e = exp_end.pop_front();
        chk("end_err", ifc.PKT_RX_ERR, e[14:11]);
        chk("end_len", ifc.PKT_RX_LEN, e[10:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    ULPIRST    = 1'b1;
    ifc.DIR    = 1'b0;
    ifc.NXT    = 1'b0;
    ifc.DATA_I = 8'h00;
    repeat (3) @(posedge ULPICLK);
    #1;
    chk("rst_start", ifc.PKT_RX_START, 0);
    chk("rst_pid", ifc.PKT_RX_PID, 0);
    chk("rst_dat", ifc.PKT_RX_DAT, 0);
    chk("rst_dvalid", ifc.PKT_RX_DVALID, 0);
    chk("rst_end", ifc.PKT_RX_END, 0);
    chk("rst_err", ifc.PKT_RX_ERR, 0);
    chk("rst_len", ifc.PKT_RX_LEN, 0);
    ULPIRST = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);

    pl = {};                       send_pkt(8'hD2, pl, 2, 0, 0);  // ACK
    pl = {8'h01, 8'h02, 8'h03};    send_pkt(8'h4B, pl, 0, 0, 0);  // DATA1 good
    pl = {8'h01, 8'h02, 8'h03};    send_pkt(8'h4B, pl, 1, 0, 0);  // bad CRC
    pl = {8'h01, 8'h02};           send_pkt(8'h5B, pl, 2, 0, 0);  // check mismatch
    pl = {8'h9C};                  send_pkt(8'hE1, pl, 2, 0, 0);  // OUT not accepted
    pl = {8'h55};                  send_pkt(8'h5A, pl, 2, 0, 0);  // NAK + extra byte
    pl = {};                       send_pkt(8'h1E, pl, 2, 0, 0);  // STALL
    pl = {};                       send_pkt(8'h96, pl, 2, 0, 1);  // NYET, DIR drop
    pl = {8'h10, 8'h20, 8'h30, 8'h40};
    send_pkt(8'hC3, pl, 0, 1, 1);                                 // RxError + DIR drop
    pl = {8'hAA};                  send_pkt(8'h4B, pl, 0, 0, 1);  // DIR drop only
    pl = {8'h05, 8'h06};           send_pkt(8'hC3, pl, 0, 1, 0);  // RxError only
    pl = {};                       send_pkt(8'hC3, pl, 0, 0, 0);  // zero-length DATA0
    pl = {8'h77};                  send_pkt(8'hC3, pl, 2, 0, 0);  // one byte only
    pl = {};
    for (int k = 0; k < MAXP; k++) pl.push_back(8'(8'hA0 + k));
    send_pkt(8'h4B, pl, 0, 0, 0);                                 // exactly MAX
    pl = {};
    for (int k = 0; k < MAXP + 4; k++) pl.push_back(8'($urandom_range(0, 255)));
    send_pkt(8'hC3, pl, 0, 0, 0);                                 // overflow

    // rx_active closes without a data byte: no START, no END
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);

    // reset in the middle of a packet
    exp_start.push_back(4'h3);
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 8'hC3);
    cyc(1'b1, 1'b1, 8'h11);
    cyc(1'b1, 1'b1, 8'h22);
    ULPIRST = 1'b1;
    ifc.DIR = 1'b0;
    ifc.NXT = 1'b0;
    @(posedge ULPICLK);
    #1;
    chk("rst_mid_outs", {ifc.PKT_RX_START, ifc.PKT_RX_PID, ifc.PKT_RX_DAT, ifc.PKT_RX_DVALID,
                         ifc.PKT_RX_END, ifc.PKT_RX_ERR, ifc.PKT_RX_LEN}, 0);
    @(posedge ULPICLK);
    #1;
    ULPIRST = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    pl = {8'h3C, 8'h5A};           send_pkt(8'h4B, pl, 0, 0, 0);  // recovery

    repeat (5) cyc(1'b0, 1'b0, 8'h00);
    chk("start_q_empty", exp_start.size(), 0);
    chk("dat_q_empty", exp_dat.size(), 0);
    chk("end_q_empty", exp_end.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
